// File: rtl/dma_w_burst_split.sv
`default_nettype none
// ============================================================================
//  Module      : dma_w_burst_split
//  Description : Accepts a write transfer command, buffers source data in a
//                FIFO and issues AXI INCR bursts (at most MAX_BURST beats and
//                never crossing a 4 KB boundary) to the DMA write engine.
//  Revision    : 1.0  initial release
// ============================================================================
module dma_w_burst_split #(
    parameter int ADDR_W     = 32,
    parameter int DMA_DATA_W = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int AXI_LEN_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DMA_DATA_W-1:0]   in_data,
    input  logic [DMA_DATA_W/8-1:0] in_strb,
    output logic                    valid,
    output logic [ADDR_W-1:0]       addr,
    output logic [AXI_LEN_W-1:0]    dma_len,
    output logic [DMA_DATA_W-1:0]   wdata,
    output logic [DMA_DATA_W/8-1:0] wstrb,
    input  logic                    ready,
    input  logic                    dma_ready,
    input  logic                    error,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int c_STRB_W  = DMA_DATA_W / 8;
    localparam int c_SHIFT   = $clog2(c_STRB_W);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = DMA_DATA_W + c_STRB_W;
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'((1 << c_SHIFT) - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FILL  = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_DATA  = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]           r_state;
    logic                 r_alive;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [LEN_W-1:0]     r_rem;
    logic [ADDR_W-1:0]    r_cur_addr;
    logic [8:0]           r_beats;
    logic [8:0]           r_beat_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic [AXI_LEN_W-1:0] r_dma_len;
    logic                 r_err;

    logic                 w_push;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_cmd_aligned;
    logic [c_ENTRY_W-1:0] w_head;

    // Beats of the next burst: limited by words left, MAX_BURST and the
    // distance (in words) to the next 4 KB boundary.
    function automatic logic [8:0] f_calc_beats(input logic [11:0] a_lo,
                                                input logic [LEN_W-1:0] rem);
        logic [12:0] room;
        logic [31:0] n;
        room = (13'd4096 - {1'b0, a_lo}) >> c_SHIFT;
        n    = 32'(room);
        if (32'(MAX_BURST) < n) n = 32'(MAX_BURST);
        if (32'(rem) < n)       n = 32'(rem);
        return n[8:0];
    endfunction

    assign w_cmd_aligned = cmd_addr & c_ALIGN_MASK;
    assign w_push        = in_valid && in_ready;
    assign w_pop         = ready && (r_state == c_DATA);
    assign w_head        = r_mem[r_rd_ptr];

    // r_alive keeps the ready outputs low while reset is held
    assign cmd_ready     = r_alive && (r_state == c_IDLE);
    assign in_ready      = r_alive && (r_count < c_CNT_W'(FIFO_DEPTH));
    assign {wstrb, wdata} = (r_count != '0) ? w_head : '0;
    assign valid         = (r_state == c_ISSUE) || (r_state == c_DATA);
    assign addr          = r_addr;
    assign dma_len       = r_dma_len;
    assign busy          = (r_state != c_IDLE);
    assign done          = (r_state == c_DONE);
    assign err           = r_err;

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_strb, in_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Command / burst sequencing
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_alive    <= 1'b0;
            r_rem      <= '0;
            r_cur_addr <= '0;
            r_beats    <= '0;
            r_beat_cnt <= '0;
            r_addr     <= '0;
            r_dma_len  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_cur_addr <= w_cmd_aligned;
                        r_rem      <= cmd_len;
                        r_err      <= 1'b0;
                        r_beat_cnt <= '0;
                        if (cmd_len == '0) begin
                            r_state <= c_DONE;
                        end else begin
                            r_beats <= f_calc_beats(w_cmd_aligned[11:0], cmd_len);
                            r_state <= c_FILL;
                        end
                    end
                end
                c_FILL: begin
                    // Issue only once the whole burst is buffered so pops never underrun
                    if (32'(r_count) >= 32'(r_beats)) begin
                        r_addr    <= r_cur_addr;
                        r_dma_len <= AXI_LEN_W'(r_beats - 9'd1);
                        r_state   <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_state <= c_DATA;
                end
                c_DATA: begin
                    if (ready) begin
                        if (r_beat_cnt == r_beats - 9'd1) begin
                            r_rem      <= r_rem - LEN_W'(r_beats);
                            r_cur_addr <= r_cur_addr + (ADDR_W'(r_beats) << c_SHIFT);
                            r_beat_cnt <= '0;
                            r_state    <= c_RESP;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 9'd1;
                        end
                    end
                end
                c_RESP: begin
                    // Errors are accumulated but never abort the command
                    if (dma_ready) begin
                        r_err <= r_err | error;
                        if (r_rem != '0) begin
                            r_beats <= f_calc_beats(r_cur_addr[11:0], r_rem);
                            r_state <= c_FILL;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_w_burst_split.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_w_burst_split
//  Description : Directed self-checking bench for dma_w_burst_split with a
//                small write-engine model and a FIFO scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dma_w_burst_split;

    localparam int ADDR_W     = 32;
    localparam int DMA_DATA_W = 32;
    localparam int LEN_W      = 16;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 32;
    localparam int AXI_LEN_W  = 8;

    logic                    clk;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [LEN_W-1:0]        cmd_len;
    logic                    in_valid;
    logic                    in_ready;
    logic [DMA_DATA_W-1:0]   in_data;
    logic [DMA_DATA_W/8-1:0] in_strb;
    logic                    valid;
    logic [ADDR_W-1:0]       addr;
    logic [AXI_LEN_W-1:0]    dma_len;
    logic [DMA_DATA_W-1:0]   wdata;
    logic [DMA_DATA_W/8-1:0] wstrb;
    logic                    ready;
    logic                    dma_ready;
    logic                    error;
    logic                    busy;
    logic                    done;
    logic                    err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          seed     = 0;
    logic [35:0] q [$];

    dma_w_burst_split #(
        .ADDR_W     (ADDR_W),
        .DMA_DATA_W (DMA_DATA_W),
        .LEN_W      (LEN_W),
        .MAX_BURST  (MAX_BURST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AXI_LEN_W  (AXI_LEN_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_strb   (in_strb),
        .valid     (valid),
        .addr      (addr),
        .dma_len   (dma_len),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .ready     (ready),
        .dma_ready (dma_ready),
        .error     (error),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n words; the scoreboard queue records {strb, data} in order
    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] d;
            logic [3:0]  s;
            d = 32'hA500_0000 + 32'(seed);
            s = 4'(seed) ^ 4'hF;
            in_valid = 1'b1;
            in_data  = d;
            in_strb  = s;
            q.push_back({s, d});
            seed++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        check("cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!valid && k < 64) begin
            tick();
            k++;
        end
        check({tag, "_valid"}, valid, 1);
    endtask

    // Write-engine model: address phase, n beats of data, response phase
    task automatic do_burst(input string tag, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len, input logic err_in);
        logic [35:0] exp_w;
        wait_valid(tag);
        check({tag, "_addr"}, addr, exp_addr);
        check({tag, "_len"}, dma_len, exp_len);
        dma_ready = 1'b0;
        tick();
        check({tag, "_hold"}, valid, 1);
        ready = 1'b1;
        for (int i = 0; i <= int'(exp_len); i++) begin
            exp_w = (q.size() > 0) ? q.pop_front() : 36'h0;
            check({tag, "_beat"}, {wstrb, wdata}, exp_w);
            tick();
        end
        ready = 1'b0;
        check({tag, "_drop"}, valid, 0);
        tick();
        check({tag, "_resp_wait"}, valid, 0);
        dma_ready = 1'b1;
        error     = err_in;
        tick();
        error     = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input logic exp_err);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, cmd_ready, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] exp_w;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_strb   = '0;
        ready     = 1'b0;
        dma_ready = 1'b1;
        error     = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", valid, 0);
        check("rst_addr", addr, 0);
        check("rst_dma_len", dma_len, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_head", {wstrb, wdata}, 0);
        rst = 1'b1;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_in_ready", in_ready, 1);

        // Single burst with two-cycle latency from accept
        push(16);
        issue_cmd(32'h1000, 16);
        check("s_fill", valid, 0);
        tick();
        check("s_latency", valid, 1);
        do_burst("s1", 32'h1000, 8'd15, 1'b0);
        finish_cmd("s", 1'b0);

        // Multi-burst; FIFO full before command
        push(32);
        check("full_in_ready", in_ready, 0);
        issue_cmd(32'h0, 40);
        do_burst("m1", 32'h0,  8'd15, 1'b0);
        do_burst("m2", 32'h40, 8'd15, 1'b0);
        push(8);
        do_burst("m3", 32'h80, 8'd7, 1'b0);
        finish_cmd("m", 1'b0);

        // Error after first burst: all bursts still issued, err sticky
        push(32);
        issue_cmd(32'h0, 40);
        do_burst("e1", 32'h0, 8'd15, 1'b1);
        check("e_sticky", err, 1);
        do_burst("e2", 32'h40, 8'd15, 1'b0);
        push(8);
        do_burst("e3", 32'h80, 8'd7, 1'b0);
        finish_cmd("e", 1'b1);

        // 4 KB boundary split; err cleared on accept
        push(8);
        issue_cmd(32'h1FF8, 8);
        check("err_cleared", err, 0);
        do_burst("k1", 32'h1FF8, 8'd1, 1'b0);
        do_burst("k2", 32'h2000, 8'd5, 1'b0);
        finish_cmd("k", 1'b0);

        // Zero length command
        issue_cmd(32'h500, 0);
        check("z_no_valid", valid, 0);
        finish_cmd("z", 1'b0);

        // Backpressure: burst waits until 16 words are buffered
        push(10);
        issue_cmd(32'h3000, 16);
        repeat (5) begin
            tick();
            check("bp_hold", valid, 0);
        end
        push(5);
        check("bp_15", valid, 0);
        push(1);
        do_burst("b1", 32'h3000, 8'd15, 1'b0);
        finish_cmd("b", 1'b0);

        // Reset during the data phase
        push(16);
        issue_cmd(32'h0, 16);
        wait_valid("r");
        tick();
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_w = (q.size() > 0) ? q.pop_front() : 36'h0;
            check("r_beat", {wstrb, wdata}, exp_w);
            tick();
        end
        rst   = 1'b0;
        ready = 1'b0;
        tick();
        check("r_valid", valid, 0);
        check("r_busy", busy, 0);
        check("r_head", {wstrb, wdata}, 0);
        check("r_in_ready", in_ready, 0);
        check("r_cmd_ready", cmd_ready, 0);
        rst = 1'b1;
        q.delete();
        tick();
        check("r_cmd_ready_rel", cmd_ready, 1);
        check("r_in_ready_rel", in_ready, 1);
        check("r_empty", {wstrb, wdata}, 0);
        push(1);
        check("r_first_push", {wstrb, wdata}, q[0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
